// File: rtl/fir_parallel_serial_if.sv
// fir_parallel_serial_if: block handshake bundle for fir_parallel_serial.
//   i_valid / o_ready / i_data : input block (upstream -> filter)
//   o_valid / i_ready / o_data : output block (filter -> downstream)
// The slave modport is the filter's view; the master modport is the environment's view.
`timescale 1ns/1ps
interface fir_parallel_serial_if #(
  parameter int unsigned NB_IN       = 8,
  parameter int unsigned NB_OUT      = 19,
  parameter int unsigned PARALLELISM = 2
) ();
  logic                                 i_valid;
  logic                                 o_ready;
  logic [PARALLELISM-1:0][NB_IN-1:0]    i_data;
  logic                                 o_valid;
  logic                                 i_ready;
  logic [PARALLELISM-1:0][NB_OUT-1:0]   o_data;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data
  );
endinterface

// File: rtl/fir_parallel_serial.sv
// fir_parallel_serial: folds a PARALLELISM-lane input block onto one serial FIR engine
// (one lane per clock, lane 0 = oldest sample) and re-packs the results into an output block.
// Ports:
//   i_clock, i_reset_n : clock (rising edge), asynchronous active-low reset
//   i_coeffs           : taps, i_coeffs[0] multiplies the newest sample; hold static while busy
//   bus (slave)        : i_valid/o_ready/i_data in, o_valid/i_ready/o_data out
//   o_stall_count      : only with FIR_PS_STALL_CNT_EN defined; saturating count of clocks the
//                        last lane waits on a stalled output
// Requires PARALLELISM >= 2 and N_COEFFS >= 2.
`timescale 1ns/1ps
module fir_parallel_serial #(
  parameter int unsigned NB_IN       = 8,
  parameter int unsigned NB_COEFFS   = 8,
  parameter int unsigned N_COEFFS    = 8,
  parameter int unsigned PARALLELISM = 2,
  parameter int unsigned NB_OUT      = NB_IN + NB_COEFFS + $clog2(N_COEFFS)
) (
  input  logic                                i_clock,
  input  logic                                i_reset_n,
  input  logic [N_COEFFS-1:0][NB_COEFFS-1:0]  i_coeffs,
  fir_parallel_serial_if.slave                bus
`ifdef FIR_PS_STALL_CNT_EN
  ,
  output logic [15:0]                         o_stall_count
`endif
);

  localparam int unsigned LANE_W  = $clog2(PARALLELISM);
  localparam int unsigned NB_PROD = NB_IN + NB_COEFFS;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PARALLELISM - 1);

  logic [PARALLELISM-1:0][NB_IN-1:0]  hold_q, hold_d;
  logic                               hold_full_q, hold_full_d;
  logic [LANE_W-1:0]                  lane_cnt_q, lane_cnt_d;
  logic [PARALLELISM-2:0][NB_OUT-1:0] pack_q, pack_d;
  // dline_q[0] is x[1] (previous sample); x[0] is the lane being processed this clock
  logic [N_COEFFS-2:0][NB_IN-1:0]     dline_q, dline_d;
  logic                               o_valid_q, o_valid_d;
  logic [PARALLELISM-1:0][NB_OUT-1:0] o_data_q, o_data_d;

  logic                               at_last_c;
  logic                               stall_c;
  logic                               last_fire_c;
  logic                               advance_c;
  logic                               accept_c;
  logic [NB_IN-1:0]                   x_new_c;
  logic signed [NB_OUT-1:0]           y_c;

  // Full-precision signed product, sign-extended to the accumulator width
  function automatic logic signed [NB_OUT-1:0] tap(input logic [NB_COEFFS-1:0] c,
                                                   input logic [NB_IN-1:0]     x);
    logic signed [NB_PROD-1:0] p;
    p = NB_PROD'($signed(c)) * NB_PROD'($signed(x));
    return NB_OUT'(p);
  endfunction

  // Handshake control; only the last lane waits for the output register to drain
  always_comb begin
    at_last_c   = hold_full_q && (lane_cnt_q == LAST_LANE);
    stall_c     = o_valid_q && !bus.i_ready;
    last_fire_c = at_last_c && !stall_c;
    advance_c   = hold_full_q && !(at_last_c && stall_c);
    accept_c    = bus.i_valid && bus.o_ready;
  end

  assign bus.o_ready = !hold_full_q || last_fire_c;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;

  // Lane select from the hold register
  always_comb begin
    x_new_c = '0;
    for (int k = 0; k < int'(PARALLELISM); k++) begin
      if (lane_cnt_q == LANE_W'(k)) x_new_c = hold_q[k];
    end
  end

  // Direct-form MAC over the pre-shift delay line plus the incoming sample
  always_comb begin
    y_c = tap(i_coeffs[0], x_new_c);
    for (int j = 1; j < int'(N_COEFFS); j++) begin
      y_c = y_c + tap(i_coeffs[j], dline_q[j-1]);
    end
  end

  // Next-state logic
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    lane_cnt_d  = lane_cnt_q;
    pack_d      = pack_q;
    dline_d     = dline_q;
    o_valid_d   = o_valid_q;
    o_data_d    = o_data_q;

    if (advance_c) begin
      dline_d[0] = x_new_c;
      for (int j = 1; j < int'(N_COEFFS) - 1; j++) begin
        dline_d[j] = dline_q[j-1];
      end
      if (at_last_c) begin
        for (int k = 0; k < int'(PARALLELISM) - 1; k++) begin
          o_data_d[k] = pack_q[k];
        end
        o_data_d[PARALLELISM-1] = y_c;
        lane_cnt_d  = '0;
        hold_full_d = 1'b0;
      end else begin
        for (int k = 0; k < int'(PARALLELISM) - 1; k++) begin
          if (lane_cnt_q == LANE_W'(k)) pack_d[k] = y_c;
        end
        lane_cnt_d = lane_cnt_q + LANE_W'(1);
      end
    end

    // A completing block keeps o_valid high even if the current one is consumed
    if (last_fire_c) begin
      o_valid_d = 1'b1;
    end else if (o_valid_q && bus.i_ready) begin
      o_valid_d = 1'b0;
    end

    // Accept overrides the hold_full clear of a completing block on the same edge
    if (accept_c) begin
      hold_d      = bus.i_data;
      hold_full_d = 1'b1;
      lane_cnt_d  = '0;
    end
  end

  // State registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      lane_cnt_q  <= '0;
      pack_q      <= '0;
      dline_q     <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      lane_cnt_q  <= lane_cnt_d;
      pack_q      <= pack_d;
      dline_q     <= dline_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
    end
  end

`ifdef FIR_PS_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of clocks the last lane is blocked by downstream
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (at_last_c && stall_c && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) stall_cnt_q <= '0;
    else            stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_count = stall_cnt_q;
`endif

endmodule
